// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for four requesters on one shared tristate bus.
// It drives the one-hot buffer enables, adds a turnaround gap between owners and cuts long tenures.
module bus_rr_arbiter #(
    parameter int MAX_HOLD  = 8,
    parameter int TA_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {IDLE, GRANT, TURNAROUND} state_t;

    state_t     state, state_nx;
    logic [3:0] grant_nx;
    logic [1:0] owner_nx, last, last_nx;
    logic [7:0] hold_cnt, hold_nx;
    logic [3:0] ta_cnt, ta_nx;
    logic       preempt_nx;

    // Search starts just after the previous owner; the previous owner itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] lst);
        logic [1:0] idx;
        rr_pick = lst;
        for (int i = 4; i >= 1; i--) begin
            idx = lst + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        owner_nx   = owner;
        last_nx    = last;
        hold_nx    = hold_cnt;
        ta_nx      = ta_cnt;
        preempt_nx = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nx = GRANT;
                    owner_nx = rr_pick(req, last);
                    last_nx  = owner_nx;
                    grant_nx = onehot(owner_nx);
                    hold_nx  = 8'd0;
                end
            end
            GRANT: begin
                if (!req[owner] ||
                    (hold_cnt == 8'(MAX_HOLD - 1) && (req & ~onehot(owner)) != 4'b0000)) begin
                    state_nx   = TURNAROUND;
                    grant_nx   = 4'b0000;
                    ta_nx      = 4'd0;
                    preempt_nx = req[owner];
                end else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
                    hold_nx = 8'd0;
                end else begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            TURNAROUND: begin
                if (ta_cnt == 4'(TA_CYCLES - 1)) begin
                    if (req != 4'b0000) begin
                        state_nx = GRANT;
                        owner_nx = rr_pick(req, last);
                        last_nx  = owner_nx;
                        grant_nx = onehot(owner_nx);
                        hold_nx  = 8'd0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    ta_nx = ta_cnt + 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 4'b0000;
            end
        endcase
    end

    // Reset leaves last=3 so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            owner    <= 2'd0;
            last     <= 2'd3;
            hold_cnt <= 8'd0;
            ta_cnt   <= 4'd0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            owner    <= owner_nx;
            last     <= last_nx;
            hold_cnt <= hold_nx;
            ta_cnt   <= ta_nx;
            busy     <= (state_nx != IDLE);
            preempt  <= preempt_nx;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Randomized and directed bench for bus_rr_arbiter with an in-bench tenure/gap model.
// Two instances run side by side: default parameters and MAX_HOLD=2/TA_CYCLES=3.
module tb_bus_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] g[2];
    logic [1:0] o[2];
    logic       b[2];
    logic       p[2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter #(.MAX_HOLD(8), .TA_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(g[0]), .owner(o[0]), .busy(b[0]), .preempt(p[0]));

    bus_rr_arbiter #(.MAX_HOLD(2), .TA_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(g[1]), .owner(o[1]), .busy(b[1]), .preempt(p[1]));

    // Model: mode 0 = bus idle, 1 = owned, 2 = dead gap.
    // held = cycles owned in the current MAX_HOLD window, dead = gap cycles so far.
    int         mh[2] = '{8, 2};
    int         ta[2] = '{1, 3};
    int         m_mode[2], m_owner[2], m_last[2], m_held[2], m_dead[2];
    bit         m_pre[2];
    logic [3:0] prev_g[2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int lst);
        for (int k = 1; k <= 4; k++)
            if (r[(lst + k) % 4]) return (lst + k) % 4;
        return lst;
    endfunction

    task automatic m_take(input int k, input logic [3:0] r);
        m_owner[k] = pick(r, m_last[k]);
        m_last[k]  = m_owner[k];
        m_held[k]  = 1;
        m_mode[k]  = 1;
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_owner[k] = 0; m_last[k] = 3;
            m_held[k] = 0; m_dead[k] = 0; m_pre[k] = 0;
            prev_g[k] = 4'b0000;
        end
    endtask

    task automatic m_step(input int k, input logic [3:0] r);
        logic [3:0] mine;
        mine = 4'b0001 << m_owner[k];
        m_pre[k] = 0;
        case (m_mode[k])
            0: if (r != 4'b0000) m_take(k, r);
            1: begin
                if (!r[m_owner[k]]) begin
                    m_mode[k] = 2; m_dead[k] = 1;
                end else if (m_held[k] == mh[k]) begin
                    if ((r & ~mine) != 4'b0000) begin
                        m_mode[k] = 2; m_dead[k] = 1; m_pre[k] = 1;
                    end else begin
                        m_held[k] = 1;
                    end
                end else begin
                    m_held[k]++;
                end
            end
            default: begin
                if (m_dead[k] == ta[k]) begin
                    if (r != 4'b0000) m_take(k, r);
                    else m_mode[k] = 0;
                end else begin
                    m_dead[k]++;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        for (int k = 0; k < 2; k++) begin
            eg = (m_mode[k] == 1) ? (4'b0001 << m_owner[k]) : 4'b0000;
            check($sformatf("grant%0d", k), 32'(g[k]), 32'(eg));
            if (eg != 4'b0000) check($sformatf("owner%0d", k), 32'(o[k]), 32'(m_owner[k]));
            check($sformatf("busy%0d", k), 32'(b[k]), 32'(m_mode[k] != 0));
            check($sformatf("preempt%0d", k), 32'(p[k]), 32'(m_pre[k]));
            check($sformatf("onehot%0d", k), 32'($countones(g[k]) <= 1), 32'd1);
            if (prev_g[k] != 4'b0000 && g[k] != 4'b0000)
                check($sformatf("no_direct_handover%0d", k), 32'(g[k]), 32'(prev_g[k]));
            prev_g[k] = g[k];
        end
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) m_step(k, r);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_grant%0d", k), 32'(g[k]), 32'h0);
            check($sformatf("rst_busy%0d", k), 32'(b[k]), 32'h0);
            check($sformatf("rst_owner%0d", k), 32'(o[k]), 32'h0);
            check($sformatf("rst_preempt%0d", k), 32'(p[k]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] seq[$];
        logic [3:0] r;
        int npre, bad_runs, run, zeros, cnt;

        // Single requester, release, back to idle
        do_reset();
        step(4'b0001);
        check("single_grant", 32'(g[0]), 32'h1);
        check("single_busy", 32'(b[0]), 32'h1);
        step(4'b0000);
        check("single_release", 32'(g[0]), 32'h0);
        step(4'b0000);
        check("single_idle", 32'(b[0]), 32'h0);
        for (int i = 0; i < 4; i++) step(4'b0000);

        // All four requesting: rotation with MAX_HOLD tenures
        do_reset();
        npre = 0; bad_runs = 0; run = 0;
        for (int i = 0; i < 40; i++) begin
            step(4'b1111);
            if (p[0]) npre++;
            if (g[0] != 4'b0000) begin
                if (prev_run_zero(run)) seq.push_back(g[0]);
                run++;
            end else begin
                if (run != 0 && run != 8) bad_runs++;
                run = 0;
            end
        end
        check("rot_count", 32'(seq.size()), 32'd5);
        if (seq.size() == 5) begin
            check("rot_0", 32'(seq[0]), 32'h1);
            check("rot_1", 32'(seq[1]), 32'h2);
            check("rot_2", 32'(seq[2]), 32'h4);
            check("rot_3", 32'(seq[3]), 32'h8);
            check("rot_4", 32'(seq[4]), 32'h1);
        end
        check("rot_tenure_len", 32'(bad_runs), 32'd0);
        check("rot_preempts", 32'(npre), 32'd4);

        // Lone owner 2 never preempted
        do_reset();
        cnt = 0; npre = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0100);
            if (g[0] == 4'b0100) cnt++;
            if (p[0]) npre++;
        end
        check("lone_grant_cycles", 32'(cnt), 32'd20);
        check("lone_preempts", 32'(npre), 32'd0);

        // Owner 1 preempted by requester 3, then regains after 3 drops
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0010);
        check("o1_grant", 32'(g[0]), 32'h2);
        for (int i = 0; i < 5; i++) step(4'b1010);
        check("o1_still", 32'(g[0]), 32'h2);
        step(4'b1010);
        check("o1_preempt", 32'(p[0]), 32'h1);
        check("o1_gap", 32'(g[0]), 32'h0);
        step(4'b1010);
        check("o3_grant", 32'(g[0]), 32'h8);
        step(4'b0010);
        step(4'b0010);
        check("o1_regain", 32'(g[0]), 32'h2);

        // Asynchronous reset between edges while owner 2 holds the bus
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0100);
        check("mid_grant", 32'(g[0]), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("async_grant", 32'(g[0]), 32'h0);
        check("async_busy", 32'(b[0]), 32'h0);
        m_reset();
        #2 rst_n = 1'b1;
        step(4'b1111);
        check("ptr_reset", 32'(g[0]), 32'h1);

        // Three-cycle turnaround on the second instance
        do_reset();
        step(4'b0001);
        check("ta3_first", 32'(g[1]), 32'h1);
        zeros = 0;
        for (int i = 0; i < 10 && g[1] != 4'b0010; i++) begin
            step(4'b0010);
            if (g[1] == 4'b0000) zeros++;
        end
        check("ta3_zero_cycles", 32'(zeros), 32'd3);
        check("ta3_next", 32'(g[1]), 32'h2);

        // Random traffic with occasional request changes
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic bit prev_run_zero(input int rl);
        return rl == 0;
    endfunction

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter sharing one 8-bit tristate bus among 4 requesters.
- Each requester drives the bus through its own 8-bit tristate buffer stage; this block generates the one-hot buffer enables (grant).
- Enforces a bus turnaround (all buffers at Z) between owners.
- Enforces a maximum tenure so no requester starves the others.

Parameters:
- MAX_HOLD, 8, max consecutive GRANT cycles before preemption when others are waiting (legal 2..255).
- TA_CYCLES, 1, dead cycles with all enables low between owners (legal 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  per-requester bus request, level-sensitive, held while ownership is wanted
- grant  output  4  one-hot registered enable to the per-requester tristate buffer ctrl; all-zero means bus floats Z
- owner  output  2  index of current/last owner; meaningful when grant != 0
- busy  output  1  1 when state != IDLE
- preempt  output  1  one-cycle pulse when tenure is cut by MAX_HOLD

Behaviour:
- One clock; reset is asynchronous and active-low.
- All outputs registered.
- Reset (async, rst_n=0): state=IDLE, grant=4'b0000, owner=0, busy=0, preempt=0, hold_cnt=0, ta_cnt=0, rr pointer last=3 (so requester 0 has first priority after reset).
- Reset mid-operation drops grant to 0 immediately (asynchronously), not on the next edge.
- States: IDLE, GRANT, TURNAROUND.
- Arbitration function: search order last+1, last+2, last+3, last (mod 4); pick the first set bit of req.
- IDLE: at a clock edge with req != 0, arbitrate. Next state is GRANT; grant=onehot(winner), owner=winner, last=winner, hold_cnt=0. Latency is 1 edge from req sampled high to grant high. With req == 0, stay in IDLE.
- GRANT: each edge evaluates in this priority order:
  - a) req[owner]==0 -> release.
  - b) hold_cnt==MAX_HOLD-1 and (req & ~onehot(owner)) != 0 -> release, preempt=1 for exactly that next cycle.
  - c) hold_cnt==MAX_HOLD-1 with no other requester -> keep grant, hold_cnt wraps to 0, no preempt.
  - d) otherwise hold_cnt+1.
- Release: grant=0, state=TURNAROUND, ta_cnt=0.
- TURNAROUND: grant stays 0 for exactly TA_CYCLES cycles. At the edge where ta_cnt==TA_CYCLES-1:
  - req != 0 -> arbitrate directly into GRANT (no extra IDLE cycle).
  - else -> IDLE.
  - Otherwise ta_cnt+1.
- Requests raised or dropped during TURNAROUND are only sampled at that final edge.
- A preempted owner keeping req high re-enters arbitration at lowest priority (last=itself). If it is the only requester at the end of TA, it regains the bus.
- Simultaneous requests: exactly one grant bit ever set. grant never changes directly from one nonzero value to another (TA enforced).
- Counters saturate never. hold_cnt is 8 bits, ta_cnt is 4 bits; both cleared on entry to their state.
- busy=1 in GRANT and TURNAROUND.
- owner holds its value through TURNAROUND and IDLE.

Test Plan:
- Reset then req=4'b0001 at cycle 0 -> grant=0001 after 1st edge, owner=0, busy=1. Drop req -> grant=0000 next edge; IDLE after TA_CYCLES=1 more edge; busy=0.
- req=4'b1111 held, MAX_HOLD=8, TA=1 -> grant sequence 0001,0010,0100,1000,0001. Each tenure is 8 cycles followed by 1 zero cycle. preempt pulses once per handover.
- Owner 2 alone holding req for 20 cycles -> grant=0100 continuously, preempt never asserted, hold_cnt wraps at 7.
- Owner 1 granted, req=4'b0010 then req[3] rises at cycle 3 -> preemption at hold_cnt=7, 1 dead cycle, grant=1000. Drop req[3], keep req[1] -> after TA, grant=0010.
- Assert rst_n=0 mid-GRANT (grant=0100) between clock edges -> grant=0000 and busy=0 before the next edge. After release with req=0001, grant=0001 (pointer reset).
- TA_CYCLES=3, req 0001 then swap to 0010 at release -> exactly 3 cycles grant=0000, then grant=0010. Glitch check: never two bits set in grant on any cycle.
